// File: rtl/test_pattern_gen_pkg.sv
// Shared encodings for the test pattern generator: pattern modes, FSM states
// and the default LFSR feedback taps.
package test_pattern_defs;

  typedef enum logic [1:0] {
    MODE_CONST = 2'd0,
    MODE_WALK  = 2'd1,
    MODE_COUNT = 2'd2,
    MODE_LFSR  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [15:0] DEFAULT_LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/test_pattern_gen_if.sv
// Control and pattern bus between a pattern consumer (master) and the
// generator (slave).
interface test_pattern_gen_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [1:0]       mode;
  logic             start;
  logic             step;
  logic [WIDTH-1:0] seed;
  logic [WIDTH-1:0] from_c_latch;
  logic [WIDTH-1:0] input_0;
  logic [WIDTH-1:0] input_1;
  logic [IDX_W-1:0] pattern_idx;
  logic             valid;
  logic             busy;
  logic             done;

  modport master (
    output mode, start, step, seed,
    input  from_c_latch, input_0, input_1, pattern_idx, valid, busy, done
  );

  modport slave (
    input  mode, start, step, seed,
    output from_c_latch, input_0, input_1, pattern_idx, valid, busy, done
  );
endinterface

// File: rtl/tpg_lfsr_step.sv
// One Fibonacci LFSR advance: shift left, feed the tap parity into bit 0.
module tpg_lfsr_step #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] LFSR_TAPS = '1
) (
  input  logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] next
);
  assign next = {state[WIDTH-2:0], ^(state & LFSR_TAPS)};
endmodule

// File: rtl/test_pattern_gen.sv
// Test pattern generator: presents DEPTH operand patterns (CONST/WALK/COUNT/LFSR),
// one per accepted step, with a C-latch emulation word trailing by one pattern.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | waiting for start; outputs hold the last presented pattern
// ST_RUN  | pattern k presented, valid/busy high; step advances k
// ST_DONE | one cycle with done high, then back to ST_IDLE
module test_pattern_gen
  import test_pattern_defs::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               DEPTH     = 8,
  parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(DEFAULT_LFSR_TAPS)
) (
  input logic               clk,
  input logic               rst,
  test_pattern_gen_if.slave bus
);
  localparam int               IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [WIDTH-1:0] ONES     = '1;

  // Bit i is the inverse of bit 2 of its own index: 0x0F repeated per byte.
  function automatic logic [WIDTH-1:0] const_word();
    logic [WIDTH-1:0] w;
    logic [31:0]      iv;
    w = '0;
    for (int i = 0; i < WIDTH; i++) begin
      iv   = 32'(i);
      w[i] = ~iv[2];
    end
    return w;
  endfunction

  localparam logic [WIDTH-1:0] CONST_WORD = const_word();

  state_e           state;
  mode_e            mode_q;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] pat;
  logic [WIDTH-1:0] latch_q;
  logic [WIDTH-1:0] lfsr_next;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;

  tpg_lfsr_step #(
    .WIDTH     (WIDTH),
    .LFSR_TAPS (LFSR_TAPS)
  ) u_lfsr_step (
    .state (pat),
    .next  (lfsr_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      mode_q  <= MODE_CONST;
      idx     <= '0;
      pat     <= CONST_WORD;
      latch_q <= ONES;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            mode_q  <= mode_e'(bus.mode);
            idx     <= '0;
            latch_q <= ONES;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state   <= ST_RUN;
            case (mode_e'(bus.mode))
              MODE_CONST: pat <= CONST_WORD;
              MODE_WALK:  pat <= WIDTH'(1);
              MODE_COUNT: pat <= bus.seed;
              default:    pat <= (bus.seed == '0) ? WIDTH'(1) : bus.seed;
            endcase
          end
        end
        ST_RUN: begin
          if (bus.step) begin
            if (idx == LAST_IDX) begin
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state   <= ST_DONE;
            end else begin
              idx     <= idx + IDX_W'(1);
              latch_q <= (mode_q == MODE_CONST) ? ONES : pat;
              case (mode_q)
                MODE_CONST: pat <= CONST_WORD;
                // pat is one-hot here, so a rotate gives 1 << ((k+1) mod WIDTH)
                MODE_WALK:  pat <= {pat[WIDTH-2:0], pat[WIDTH-1]};
                MODE_COUNT: pat <= pat + WIDTH'(1);
                default:    pat <= lfsr_next;
              endcase
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.from_c_latch = latch_q;
  assign bus.input_0      = pat;
  assign bus.input_1      = ~pat;
  assign bus.pattern_idx  = idx;
  assign bus.valid        = valid_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_test_pattern_gen.sv
// Directed vector bench for test_pattern_gen at WIDTH=16, DEPTH=8.
module tb_test_pattern_gen;

  logic clk;
  logic rst;

  test_pattern_gen_if #(.WIDTH(16), .DEPTH(8)) bus ();

  test_pattern_gen #(.WIDTH(16), .DEPTH(8), .LFSR_TAPS(16'hB400)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        start;
    logic        step;
    logic [1:0]  mode;
    logic [15:0] seed;
    logic [15:0] latch;
    logic [15:0] in0;
    logic [15:0] in1;
    logic [2:0]  idx;
    logic        valid;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t vecs[$];
  int   n_vec;
  int   n_err;

  function automatic vec_t mk(input logic r, input logic s, input logic st,
                              input logic [1:0] m, input logic [15:0] sd,
                              input logic [15:0] la, input logic [15:0] i0,
                              input logic [15:0] i1, input logic [2:0] k,
                              input logic v, input logic b, input logic d);
    vec_t x;
    x.rst = r; x.start = s; x.step = st; x.mode = m; x.seed = sd;
    x.latch = la; x.in0 = i0; x.in1 = i1; x.idx = k;
    x.valid = v; x.busy = b; x.done = d;
    return x;
  endfunction

  task automatic drive(input logic r, input logic s, input logic st,
                       input logic [1:0] m, input logic [15:0] sd);
    @(negedge clk);
    rst       = r;
    bus.start = s;
    bus.step  = st;
    bus.mode  = m;
    bus.seed  = sd;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic ok, input int act, input int exp);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int   steps;
    int   done_cnt;
    logic seen;

    n_vec = 0;
    n_err = 0;
    rst = 1'b1; bus.start = 1'b0; bus.step = 1'b0; bus.mode = 2'd0; bus.seed = 16'h0;

    //             rst st  stp mode seed      latch     in0       in1       k  v  b  d
    vecs.push_back(mk(1, 0, 0, 2'd0, 16'h0000, 16'hFFFF, 16'h0F0F, 16'hF0F0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 2'd0, 16'h0000, 16'hFFFF, 16'h0F0F, 16'hF0F0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 2'd0, 16'h0000, 16'hFFFF, 16'h0F0F, 16'hF0F0, 0, 0, 0, 0));
    // WALK run, with a restart attempt and a mode change mid-run
    vecs.push_back(mk(0, 1, 0, 2'd1, 16'h0000, 16'hFFFF, 16'h0001, 16'hFFFE, 0, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 2'd2, 16'h5555, 16'hFFFF, 16'h0001, 16'hFFFE, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 2'd2, 16'h5555, 16'h0001, 16'h0002, 16'hFFFD, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 2'd3, 16'h0000, 16'h0002, 16'h0004, 16'hFFFB, 2, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 2'd3, 16'h0000, 16'h0002, 16'h0004, 16'hFFFB, 2, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 2'd1, 16'h0000, 16'h0004, 16'h0008, 16'hFFF7, 3, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 2'd1, 16'h0000, 16'h0008, 16'h0010, 16'hFFEF, 4, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 2'd1, 16'h0000, 16'h0010, 16'h0020, 16'hFFDF, 5, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 2'd1, 16'h0000, 16'h0020, 16'h0040, 16'hFFBF, 6, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 2'd1, 16'h0000, 16'h0040, 16'h0080, 16'hFF7F, 7, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 2'd1, 16'h0000, 16'h0040, 16'h0080, 16'hFF7F, 7, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 2'd1, 16'h0000, 16'h0040, 16'h0080, 16'hFF7F, 7, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 2'd1, 16'h0000, 16'h0040, 16'h0080, 16'hFF7F, 7, 0, 0, 0));
    // COUNT wrap, seed changed mid-run
    vecs.push_back(mk(0, 1, 0, 2'd2, 16'hFFFE, 16'hFFFF, 16'hFFFE, 16'h0001, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 2'd2, 16'h1234, 16'hFFFE, 16'hFFFF, 16'h0000, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 2'd2, 16'h1234, 16'hFFFF, 16'h0000, 16'hFFFF, 2, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 2'd0, 16'h0000, 16'hFFFF, 16'h0F0F, 16'hF0F0, 0, 0, 0, 0));
    // LFSR, zero seed then 8000
    vecs.push_back(mk(0, 1, 0, 2'd3, 16'h0000, 16'hFFFF, 16'h0001, 16'hFFFE, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 2'd3, 16'h0000, 16'h0001, 16'h0002, 16'hFFFD, 1, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 2'd0, 16'h0000, 16'hFFFF, 16'h0F0F, 16'hF0F0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 2'd3, 16'h8000, 16'hFFFF, 16'h8000, 16'h7FFF, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 2'd3, 16'h8000, 16'h8000, 16'h0001, 16'hFFFE, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 2'd3, 16'h8000, 16'h0001, 16'h0002, 16'hFFFD, 2, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 2'd0, 16'h0000, 16'hFFFF, 16'h0F0F, 16'hF0F0, 0, 0, 0, 0));
    // CONST: latch word stays all ones
    vecs.push_back(mk(0, 1, 0, 2'd0, 16'h0000, 16'hFFFF, 16'h0F0F, 16'hF0F0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 2'd0, 16'h0000, 16'hFFFF, 16'h0F0F, 16'hF0F0, 1, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 2'd0, 16'h0000, 16'hFFFF, 16'h0F0F, 16'hF0F0, 0, 0, 0, 0));
    // reset at k=4 together with step and start
    vecs.push_back(mk(0, 1, 0, 2'd2, 16'h0010, 16'hFFFF, 16'h0010, 16'hFFEF, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 2'd2, 16'h0010, 16'h0010, 16'h0011, 16'hFFEE, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 2'd2, 16'h0010, 16'h0011, 16'h0012, 16'hFFED, 2, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 2'd2, 16'h0010, 16'h0012, 16'h0013, 16'hFFEC, 3, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 2'd2, 16'h0010, 16'h0013, 16'h0014, 16'hFFEB, 4, 1, 1, 0));
    vecs.push_back(mk(1, 1, 1, 2'd2, 16'h0010, 16'hFFFF, 16'h0F0F, 16'hF0F0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 2'd2, 16'h0010, 16'hFFFF, 16'h0F0F, 16'hF0F0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].start, vecs[i].step, vecs[i].mode, vecs[i].seed);
      n_vec++;
      if (bus.from_c_latch !== vecs[i].latch || bus.input_0 !== vecs[i].in0 ||
          bus.input_1 !== vecs[i].in1 || bus.pattern_idx !== vecs[i].idx ||
          bus.valid !== vecs[i].valid || bus.busy !== vecs[i].busy ||
          bus.done !== vecs[i].done) begin
        n_err++;
        $display("FAIL vec%0d: got latch=%h in0=%h in1=%h idx=%0d v=%b b=%b d=%b, expected latch=%h in0=%h in1=%h idx=%0d v=%b b=%b d=%b",
                 i, bus.from_c_latch, bus.input_0, bus.input_1, bus.pattern_idx,
                 bus.valid, bus.busy, bus.done, vecs[i].latch, vecs[i].in0,
                 vecs[i].in1, vecs[i].idx, vecs[i].valid, vecs[i].busy, vecs[i].done);
      end
    end

    // Full WALK run stepped continuously: done must appear after the 8th step
    // and stay high for exactly one cycle.
    drive(1, 0, 0, 2'd0, 16'h0);
    drive(0, 1, 0, 2'd1, 16'h0);
    steps = 0;
    done_cnt = 0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      drive(0, 0, 1, 2'd1, 16'h0);
      steps++;
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        done_cnt++;
      end
    end
    check("done_seen", seen === 1'b1, int'(seen), 1);
    check("steps_to_done", steps == 8, steps, 8);
    for (int c = 0; c < 4; c++) begin
      drive(0, 0, 0, 2'd1, 16'h0);
      if (bus.done === 1'b1) done_cnt++;
    end
    check("done_width", done_cnt == 1, done_cnt, 1);
    check("idle_hold_0080", bus.input_0 === 16'h0080, int'(bus.input_0), 16'h0080);
    check("idle_valid", bus.valid === 1'b0 && bus.busy === 1'b0, int'({bus.valid, bus.busy}), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
